// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
//
// Multi-cycle instruction sequencer. It steps each instruction through
// FETCH -> FWAIT -> DECODE -> EXEC -> [MEM -> MWAIT] -> WB. It issues one-cycle
// memory requests and waits for the memory completion strobe. If memory does
// not respond within MEM_TIMEOUT wait cycles, it sets a sticky fault and halts.
//
// Parameters
//   HALT_OP     : opcode that, seen at write-back, stops sequencing in HALT
//   MEM_TIMEOUT : wait cycles (1..15) without MemReady before Fault is raised
//
// Ports
//   CLK        in   clock; all state changes on its rising edge
//   Reset      in   synchronous, active-high reset
//   OPCODE     in   [4:0] opcode field of the instruction register
//   MemRead    in   data-read request from the control unit
//   MemWrite   in   data-write request from the control unit
//   MemReady   in   memory completion strobe (looked at only in FWAIT/MWAIT)
//   MemStart   out  one-cycle memory access request (FETCH and MEM)
//   MemFetch   out  1 = instruction fetch access, 0 = data access
//   IRWrite    out  instruction register load enable (FWAIT and MemReady)
//   Commit     out  write-enable gate, high only in the WB cycle
//   Phase      out  [2:0] current state encoding
//   Fault      out  sticky memory-timeout flag
//   InstrCount out  [15:0] retired instruction count, saturating
// -----------------------------------------------------------------------------
module cycle_sequencer #(
    parameter logic [4:0]  HALT_OP     = 5'b11111,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [4:0]  OPCODE,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemReady,
    output logic        MemStart,
    output logic        MemFetch,
    output logic        IRWrite,
    output logic        Commit,
    output logic [2:0]  Phase,
    output logic        Fault,
    output logic [15:0] InstrCount
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        FWAIT  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        MWAIT  = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } seqState;

    // The wait counter value at the start of the last tolerated wait cycle.
    // If MemReady is still low when the counter holds this value, the
    // counter would reach MEM_TIMEOUT, so the access has timed out.
    localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

    seqState     state;
    logic [3:0]  waitCnt;
    logic        faultReg;
    logic [15:0] instrCnt;

    // State machine, wait counter, sticky fault and retired-instruction counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= FETCH;
            waitCnt  <= 4'd0;
            faultReg <= 1'b0;
            instrCnt <= 16'd0;
        end else begin
            case (state)
                FETCH: begin
                    waitCnt <= 4'd0;
                    state   <= FWAIT;
                end
                FWAIT: begin
                    // MemReady wins over a timeout in the same cycle.
                    if (MemReady) begin
                        state <= DECODE;
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                        if (waitCnt == TIMEOUT_LAST) begin
                            faultReg <= 1'b1;
                            state    <= HALT;
                        end
                    end
                end
                DECODE: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (MemRead || MemWrite) begin
                        state <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    waitCnt <= 4'd0;
                    state   <= MWAIT;
                end
                MWAIT: begin
                    if (MemReady) begin
                        state <= WB;
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                        if (waitCnt == TIMEOUT_LAST) begin
                            faultReg <= 1'b1;
                            state    <= HALT;
                        end
                    end
                end
                WB: begin
                    if (instrCnt != 16'hFFFF) begin
                        instrCnt <= instrCnt + 16'd1;
                    end
                    if (OPCODE == HALT_OP) begin
                        state <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    // Moore output decode from the state register. While Reset is high,
    // the outputs show their reset values even before the first clock edge.
    // IRWrite is the only output that also follows MemReady.
    always_comb begin
        MemStart   = 1'b0;
        MemFetch   = 1'b0;
        IRWrite    = 1'b0;
        Commit     = 1'b0;
        Phase      = 3'd0;
        Fault      = 1'b0;
        InstrCount = 16'd0;
        if (Reset) begin
            MemFetch = 1'b1;
        end else begin
            Phase      = state;
            Fault      = faultReg;
            InstrCount = instrCnt;
            case (state)
                FETCH: begin
                    MemStart = 1'b1;
                    MemFetch = 1'b1;
                end
                FWAIT: begin
                    MemFetch = 1'b1;
                    IRWrite  = MemReady;
                end
                MEM: begin
                    MemStart = 1'b1;
                end
                WB: begin
                    Commit = 1'b1;
                end
                default: begin
                    MemStart = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cycle_sequencer
//
// Directed bench for cycle_sequencer. The stimulus process drives one cycle
// at a time. For each cycle it queues the expected outputs: the hand-written
// phase, fault and count, plus the strobes that follow from that phase. A
// separate monitor pops each expectation on the falling edge and compares it
// with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_cycle_sequencer;

    logic        CLK;
    logic        Reset;
    logic [4:0]  OPCODE;
    logic        MemRead;
    logic        MemWrite;
    logic        MemReady;
    logic        MemStart;
    logic        MemFetch;
    logic        IRWrite;
    logic        Commit;
    logic [2:0]  Phase;
    logic        Fault;
    logic [15:0] InstrCount;

    typedef struct {
        string       nm;
        logic [2:0]  ph;
        logic        st;
        logic        fe;
        logic        ir;
        logic        cm;
        logic        flt;
        logic [15:0] cnt;
    } expT;

    expT         expQ[$];
    expT         monE;
    logic [23:0] act;
    logic [23:0] want;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt;

    cycle_sequencer dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .OPCODE     (OPCODE),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemReady   (MemReady),
        .MemStart   (MemStart),
        .MemFetch   (MemFetch),
        .IRWrite    (IRWrite),
        .Commit     (Commit),
        .Phase      (Phase),
        .Fault      (Fault),
        .InstrCount (InstrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: compares each queued expectation against the DUT outputs.
    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            act  = {Phase, MemStart, MemFetch, IRWrite, Commit, Fault, InstrCount};
            want = {monE.ph, monE.st, monE.fe, monE.ir, monE.cm, monE.flt, monE.cnt};
            checks = checks + 1;
            if (act !== want) begin
                errors = errors + 1;
                $display("FAIL %s t=%0t got ph=%0d st=%b fe=%b ir=%b cm=%b flt=%b cnt=%h want ph=%0d st=%b fe=%b ir=%b cm=%b flt=%b cnt=%h",
                         monE.nm, $time, Phase, MemStart, MemFetch, IRWrite, Commit, Fault, InstrCount,
                         monE.ph, monE.st, monE.fe, monE.ir, monE.cm, monE.flt, monE.cnt);
            end
        end
    end

    // Drives one cycle and queues its expected outputs.
    // Strobes follow from the phase: MemStart in FETCH/MEM, MemFetch in
    // FETCH/FWAIT, IRWrite in FWAIT with MemReady, Commit in WB.
    task automatic step(input logic rst, input logic rdy, input logic [2:0] ph,
                        input logic flt, input logic [15:0] c, input string nm);
        expT e;
        Reset    = rst;
        MemReady = rdy;
        e.nm = nm;
        if (rst) begin
            e.ph = 3'd0; e.st = 1'b0; e.fe = 1'b1; e.ir = 1'b0;
            e.cm = 1'b0; e.flt = 1'b0; e.cnt = 16'd0;
        end else begin
            e.ph  = ph;
            e.st  = (ph == 3'd0) || (ph == 3'd4);
            e.fe  = (ph == 3'd0) || (ph == 3'd1);
            e.ir  = (ph == 3'd1) && rdy;
            e.cm  = (ph == 3'd6);
            e.flt = flt;
            e.cnt = c;
        end
        expQ.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Five-cycle non-memory instruction with MemReady on the first wait cycle.
    task automatic plainInstr(input logic [15:0] c, input string nm);
        step(1'b0, 1'b0, 3'd0, 1'b0, c, nm);
        step(1'b0, 1'b1, 3'd1, 1'b0, c, nm);
        step(1'b0, 1'b0, 3'd2, 1'b0, c, nm);
        step(1'b0, 1'b0, 3'd3, 1'b0, c, nm);
        step(1'b0, 1'b0, 3'd6, 1'b0, c, nm);
    endtask

    // Watchdog: the run is a fixed number of cycles, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got t=%0t want < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        OPCODE   = 5'd0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemReady = 1'b0;
        @(posedge CLK);
        #1;

        // Reset state. MemReady is high but must have no effect.
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'd0, "reset0");
        step(1'b1, 1'b1, 3'd0, 1'b0, 16'd0, "reset1");

        // Non-memory instruction, MemReady high every cycle: phases 0,1,2,3,6,0.
        step(1'b0, 1'b1, 3'd0, 1'b0, 16'd0, "nomem_fetch");
        step(1'b0, 1'b1, 3'd1, 1'b0, 16'd0, "nomem_fwait");
        step(1'b0, 1'b1, 3'd2, 1'b0, 16'd0, "nomem_decode");
        step(1'b0, 1'b1, 3'd3, 1'b0, 16'd0, "nomem_exec");
        step(1'b0, 1'b1, 3'd6, 1'b0, 16'd0, "nomem_wb");

        // Load instruction, MemReady 3 cycles late in MWAIT. WB is the tenth cycle.
        MemRead = 1'b1;
        step(1'b0, 1'b0, 3'd0, 1'b0, 16'd1, "load_fetch");
        step(1'b0, 1'b1, 3'd1, 1'b0, 16'd1, "load_fwait");
        step(1'b0, 1'b0, 3'd2, 1'b0, 16'd1, "load_decode");
        step(1'b0, 1'b0, 3'd3, 1'b0, 16'd1, "load_exec");
        step(1'b0, 1'b1, 3'd4, 1'b0, 16'd1, "load_mem");
        step(1'b0, 1'b0, 3'd5, 1'b0, 16'd1, "load_mwait1");
        step(1'b0, 1'b0, 3'd5, 1'b0, 16'd1, "load_mwait2");
        step(1'b0, 1'b0, 3'd5, 1'b0, 16'd1, "load_mwait3");
        step(1'b0, 1'b1, 3'd5, 1'b0, 16'd1, "load_mwait4");
        step(1'b0, 1'b0, 3'd6, 1'b0, 16'd1, "load_wb");
        MemRead = 1'b0;

        // Store instruction with immediate MemReady: seven cycles.
        MemWrite = 1'b1;
        step(1'b0, 1'b0, 3'd0, 1'b0, 16'd2, "store_fetch");
        step(1'b0, 1'b1, 3'd1, 1'b0, 16'd2, "store_fwait");
        step(1'b0, 1'b0, 3'd2, 1'b0, 16'd2, "store_decode");
        step(1'b0, 1'b0, 3'd3, 1'b0, 16'd2, "store_exec");
        step(1'b0, 1'b0, 3'd4, 1'b0, 16'd2, "store_mem");
        step(1'b0, 1'b1, 3'd5, 1'b0, 16'd2, "store_mwait");
        step(1'b0, 1'b0, 3'd6, 1'b0, 16'd2, "store_wb");
        MemWrite = 1'b0;

        // MemReady on the 15th wait cycle takes priority over the timeout.
        step(1'b0, 1'b0, 3'd0, 1'b0, 16'd3, "late_fetch");
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, 3'd1, 1'b0, 16'd3, "late_fwait");
        end
        step(1'b0, 1'b1, 3'd1, 1'b0, 16'd3, "late_fwait15");
        step(1'b0, 1'b0, 3'd2, 1'b0, 16'd3, "late_decode");
        step(1'b0, 1'b0, 3'd3, 1'b0, 16'd3, "late_exec");
        step(1'b0, 1'b0, 3'd6, 1'b0, 16'd3, "late_wb");

        // Run plain instructions until InstrCount reaches 37.
        cnt = 16'd4;
        while (cnt != 16'd37) begin
            plainInstr(cnt, "plain_loop");
            cnt = cnt + 16'd1;
        end

        // Reset during MWAIT at count 37 aborts the load without a commit.
        MemRead = 1'b1;
        step(1'b0, 1'b0, 3'd0, 1'b0, 16'd37, "abort_fetch");
        step(1'b0, 1'b1, 3'd1, 1'b0, 16'd37, "abort_fwait");
        step(1'b0, 1'b0, 3'd2, 1'b0, 16'd37, "abort_decode");
        step(1'b0, 1'b0, 3'd3, 1'b0, 16'd37, "abort_exec");
        step(1'b0, 1'b0, 3'd4, 1'b0, 16'd37, "abort_mem");
        step(1'b0, 1'b0, 3'd5, 1'b0, 16'd37, "abort_mwait");
        step(1'b1, 1'b1, 3'd0, 1'b0, 16'd0, "abort_reset");
        MemRead = 1'b0;
        step(1'b0, 1'b1, 3'd0, 1'b0, 16'd0, "abort_refetch");
        step(1'b0, 1'b1, 3'd1, 1'b0, 16'd0, "abort_fwait2");
        step(1'b0, 1'b0, 3'd2, 1'b0, 16'd0, "abort_decode2");
        step(1'b0, 1'b0, 3'd3, 1'b0, 16'd0, "abort_exec2");
        step(1'b0, 1'b0, 3'd6, 1'b0, 16'd0, "abort_wb2");

        // Halt opcode at WB: one commit, then HALT holds with all strobes low.
        OPCODE = 5'b11111;
        plainInstr(16'd1, "halt_instr");
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'(i % 2), 3'd7, 1'b0, 16'd2, "halt_hold");
        end
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'd0, "halt_reset");
        OPCODE = 5'd0;

        // Saturation: preload FFFE while in FETCH, then retire three instructions.
        force dut.instrCnt = 16'hFFFE;
        #1;
        release dut.instrCnt;
        plainInstr(16'hFFFE, "sat_1");
        plainInstr(16'hFFFF, "sat_2");
        plainInstr(16'hFFFF, "sat_3");

        // Fetch timeout: 15 wait cycles without MemReady lead to Fault and HALT.
        // A later MemReady is ignored.
        step(1'b0, 1'b0, 3'd0, 1'b0, 16'hFFFF, "tmo_fetch");
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 3'd1, 1'b0, 16'hFFFF, "tmo_fwait");
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 3'd7, 1'b1, 16'hFFFF, "tmo_halt");
        end
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'd0, "tmo_reset");
        step(1'b0, 1'b0, 3'd0, 1'b0, 16'd0, "tmo_refetch");
        step(1'b0, 1'b0, 3'd1, 1'b0, 16'd0, "tmo_fwait_after");

        // Let the monitor consume the last entry, then confirm the queue drained.
        @(negedge CLK);
        #1;
        checks = checks + 1;
        if (expQ.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d entries left want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
